// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator motion controller and its timer.
package elevator_pkg;

    localparam int FLOOR_W = 4;

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [2:0]         state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CHECK     = 3'd1;
    localparam state_t ST_MOVE_UP   = 3'd2;
    localparam state_t ST_MOVE_DOWN = 3'd3;
    localparam state_t ST_DOOR_OPEN = 3'd4;

    // Bits needed to count 0..max(a,b)-1, never less than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/elevator_motion_ctrl_timer.sv
// Clear/enable up-counter with a terminal-count flag; shared by move and door states.
module cycle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last_count,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
    assign done  = enable && (count_reg == last_count);

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Single-request elevator controller: steps the car one floor per comparator check,
// opens the door on arrival. All outputs are registered Moore outputs.
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 16,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [3:0] req_floor,
    output logic       req_ready,
    output logic       req_err,
    output logic [3:0] target_floor,
    output logic [3:0] current_floor,
    input  logic       cmp_a_bigger,
    input  logic       cmp_a_smaller,
    input  logic       cmp_equals,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       busy,
    output logic       cmp_fault
);

    localparam int             TW          = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [TW-1:0]  TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]  DOOR_LAST   = TW'(DOOR_CYCLES - 1);
    localparam floor_t         TOP_FLOOR   = floor_t'(NUM_FLOORS - 1);

    state_t  state_reg, state_next;
    floor_t  target_reg, target_next;
    floor_t  current_reg, current_next;
    logic    req_err_reg, req_err_next;
    logic    cmp_fault_reg, cmp_fault_next;
    logic    motor_up_reg, motor_down_reg, door_open_reg, busy_reg, req_ready_reg;

    logic          timer_enable, timer_clear, timer_done;
    logic [TW-1:0] timer_last, timer_count;

    assign timer_enable = (state_reg == ST_MOVE_UP) || (state_reg == ST_MOVE_DOWN)
                       || (state_reg == ST_DOOR_OPEN);
    assign timer_clear  = timer_done || !timer_enable;
    assign timer_last   = (state_reg == ST_DOOR_OPEN) ? DOOR_LAST : TRAVEL_LAST;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (timer_clear),
        .enable     (timer_enable),
        .last_count (timer_last),
        .count      (timer_count),
        .done       (timer_done)
    );

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        current_next   = current_reg;
        req_err_next   = 1'b0;
        cmp_fault_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (int'(req_floor) < NUM_FLOORS) begin
                        target_next = req_floor;
                        state_next  = ST_CHECK;
                    end else begin
                        req_err_next = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                case ({cmp_a_bigger, cmp_a_smaller, cmp_equals})
                    3'b001:  state_next = ST_DOOR_OPEN;
                    3'b100:  state_next = ST_MOVE_UP;
                    3'b010:  state_next = ST_MOVE_DOWN;
                    default: begin
                        cmp_fault_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                endcase
            end
            ST_MOVE_UP: begin
                if (timer_done) begin
                    // A comparator that keeps saying "up" at the top floor is lying.
                    if (current_reg == TOP_FLOOR) begin
                        cmp_fault_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        current_next = current_reg + floor_t'(1);
                        state_next   = ST_CHECK;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (timer_done) begin
                    if (current_reg == floor_t'(0)) begin
                        cmp_fault_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        current_next = current_reg - floor_t'(1);
                        state_next   = ST_CHECK;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            target_reg     <= '0;
            current_reg    <= '0;
            req_err_reg    <= 1'b0;
            cmp_fault_reg  <= 1'b0;
            motor_up_reg   <= 1'b0;
            motor_down_reg <= 1'b0;
            door_open_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            current_reg    <= current_next;
            req_err_reg    <= req_err_next;
            cmp_fault_reg  <= cmp_fault_next;
            motor_up_reg   <= (state_next == ST_MOVE_UP);
            motor_down_reg <= (state_next == ST_MOVE_DOWN);
            door_open_reg  <= (state_next == ST_DOOR_OPEN);
            busy_reg       <= (state_next != ST_IDLE);
            req_ready_reg  <= (state_next == ST_IDLE);
        end
    end

    assign req_ready     = req_ready_reg;
    assign req_err       = req_err_reg;
    assign target_floor  = target_reg;
    assign current_floor = current_reg;
    assign motor_up      = motor_up_reg;
    assign motor_down    = motor_down_reg;
    assign door_open     = door_open_reg;
    assign busy          = busy_reg;
    assign cmp_fault     = cmp_fault_reg;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench: driver predicts each request's outcome from floor arithmetic,
// a negedge monitor pops and compares on door-open, req_err and cmp_fault events.
module tb_elevator_motion_ctrl;

    localparam int NF = 10;
    localparam int TC = 4;
    localparam int DC = 8;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_floor;
    logic       req_ready, req_err, motor_up, motor_down, door_open, busy, cmp_fault;
    logic [3:0] target_floor, current_floor;
    logic       cmp_a_bigger, cmp_a_smaller, cmp_equals;
    logic       force_en;
    logic [2:0] force_val;

    // Real comparator between the floor outputs and the cmp inputs, with an override.
    assign cmp_a_bigger  = force_en ? force_val[2] : (target_floor > current_floor);
    assign cmp_a_smaller = force_en ? force_val[1] : (target_floor < current_floor);
    assign cmp_equals    = force_en ? force_val[0] : (target_floor == current_floor);

    elevator_motion_ctrl #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_floor     (req_floor),
        .req_ready     (req_ready),
        .req_err       (req_err),
        .target_floor  (target_floor),
        .current_floor (current_floor),
        .cmp_a_bigger  (cmp_a_bigger),
        .cmp_a_smaller (cmp_a_smaller),
        .cmp_equals    (cmp_equals),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .busy          (busy),
        .cmp_fault     (cmp_fault)
    );

    typedef struct {
        int kind;   // 0 arrival, 1 req_err, 2 cmp_fault
        int acc;    // cycle the request was accepted
        int lat;
        int floor;
        int up;
        int down;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   model_floor = 0;
    int   model_target = 0;
    int   up_cnt = 0, down_cnt = 0, door_len = 0;
    logic prev_door = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check_event(input int kind, input int floor_seen);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d with nothing expected (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (cyc - e.acc) != e.lat || floor_seen != e.floor
                || up_cnt != e.up || down_cnt != e.down) begin
                miscompares++;
                $display("FAIL event: got kind=%0d lat=%0d floor=%0d up=%0d down=%0d expected kind=%0d lat=%0d floor=%0d up=%0d down=%0d",
                         kind, cyc - e.acc, floor_seen, up_cnt, down_cnt,
                         e.kind, e.lat, e.floor, e.up, e.down);
            end else begin
                $display("event kind=%0d lat=%0d floor=%0d up=%0d down=%0d ok",
                         kind, cyc - e.acc, floor_seen, up_cnt, down_cnt);
            end
        end
        up_cnt   = 0;
        down_cnt = 0;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                up_cnt    = 0;
                down_cnt  = 0;
                door_len  = 0;
                prev_door = 1'b0;
            end else begin
                vectors++;
                if ((motor_up && motor_down) || (busy == req_ready)) begin
                    miscompares++;
                    $display("FAIL invariant: got up=%0b down=%0b busy=%0b ready=%0b expected exclusive motors and busy=!ready",
                             motor_up, motor_down, busy, req_ready);
                end
                up_cnt   += int'(motor_up);
                down_cnt += int'(motor_down);
                if (door_open && !prev_door) check_event(0, int'(current_floor));
                if (door_open) begin
                    door_len++;
                end else if (prev_door) begin
                    chk("door_len", door_len, DC);
                    chk("ready_after_door", int'(req_ready), 1);
                    door_len = 0;
                end
                if (req_err)   check_event(1, int'(target_floor));
                if (cmp_fault) check_event(2, int'(current_floor));
                prev_door = door_open;
            end
        end
    end

    // Waits until the DUT is idle and the scoreboard drained; junk requests while busy.
    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 600) begin
            if (sb.size() == 0 && req_ready) break;
            req_valid = req_ready ? 1'b0 : 1'($urandom_range(0, 1));
            req_floor = 4'($urandom_range(0, 15));
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        if (n >= 600) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got %0d pending events expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input int f, input logic [2:0] fv, input logic fe);
        exp_t e;
        int   d;
        wait_idle();
        force_en = fe;
        force_val = fv;
        e.acc = cyc;
        e.up = 0;
        e.down = 0;
        if (f >= NF) begin
            e.kind = 1; e.lat = 1; e.floor = model_target;
        end else begin
            model_target = f;
            if (fe && fv != 3'b001 && fv != 3'b010 && fv != 3'b100) begin
                e.kind = 2; e.lat = 2; e.floor = model_floor;
            end else if (fe && fv == 3'b100 && model_floor == NF - 1) begin
                e.kind = 2; e.lat = 2 + TC; e.floor = model_floor; e.up = TC;
            end else begin
                d = (f > model_floor) ? f - model_floor : model_floor - f;
                e.kind = 0;
                e.lat  = 2 + d * (TC + 1);
                if (f > model_floor) e.up = d * TC;
                else e.down = d * TC;
                model_floor = f;
                e.floor = f;
            end
        end
        sb.push_back(e);
        $display("request floor=%0d force=%0b/%03b expect kind=%0d lat=%0d", f, fe, fv, e.kind, e.lat);
        req_valid = 1'b1;
        req_floor = f[3:0];
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    logic [2:0] bad_cmp [5];

    initial begin
        int r, f;
        bad_cmp = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_floor = 4'd0;
        force_en = 1'b0;
        force_val = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_current_floor", int'(current_floor), 0);
        chk("rst_target_floor", int'(target_floor), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_motor_up", int'(motor_up), 0);
        chk("rst_motor_down", int'(motor_down), 0);
        chk("rst_door_open", int'(door_open), 0);
        chk("rst_req_err", int'(req_err), 0);
        chk("rst_cmp_fault", int'(cmp_fault), 0);

        issue(3, 3'b000, 1'b0);
        issue(1, 3'b000, 1'b0);
        issue(1, 3'b000, 1'b0);
        issue(12, 3'b000, 1'b0);
        issue(5, 3'b000, 1'b1);
        issue(9, 3'b000, 1'b0);
        issue(9, 3'b100, 1'b1);
        issue(0, 3'b110, 1'b1);
        issue(0, 3'b000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            f = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            if (r == 0) issue(f, bad_cmp[$urandom_range(0, 4)], 1'b1);
            else issue(f, 3'b000, 1'b0);
        end

        // Reset while the car is moving up.
        issue(0, 3'b000, 1'b0);
        wait_idle();
        req_valid = 1'b1;
        req_floor = 4'd8;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_motor_up", int'(motor_up), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_motor_up", int'(motor_up), 0);
        chk("async_rst_current_floor", int'(current_floor), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_floor = 0;
        model_target = 0;
        sb.delete();
        @(negedge clk);
        issue(2, 3'b000, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
Sequential floor controller that sits directly upstream and downstream of the 4-bit floor comparator.
- Latches one floor request and drives target_floor (comparator A side) and current_floor (comparator B side).
- Consumes the comparator's ABigger/ASmaller/equals results to step the car up or down one floor at a time.
- Opens the door on arrival, then returns to idle.

Parameters:
NUM_FLOORS, 16, number of valid floors (0..NUM_FLOORS-1); legal range 2..16.
TRAVEL_CYCLES, 4, clock cycles spent in a move state per floor; minimum 1.
DOOR_CYCLES, 8, clock cycles the door stays open on arrival; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  floor request present.
req_floor  input  4  requested floor number.
req_ready  output  1  high in IDLE only; request accepted on req_valid && req_ready.
req_err  output  1  one-cycle pulse when an accepted request has req_floor >= NUM_FLOORS.
target_floor  output  4  latched destination; drives comparator A3..A0.
current_floor  output  4  car position; drives comparator B3..B0.
cmp_a_bigger  input  1  comparator ABigger (target > current).
cmp_a_smaller  input  1  comparator ASmaller (target < current).
cmp_equals  input  1  comparator equals.
motor_up  output  1  high while in MOVE_UP.
motor_down  output  1  high while in MOVE_DOWN.
door_open  output  1  high while in DOOR_OPEN.
busy  output  1  high in every state except IDLE.
cmp_fault  output  1  one-cycle pulse when comparator inputs are not one-hot in CHECK.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low, and named rst_n.
- Reset state: IDLE. target_floor = 0, current_floor = 0, timer = 0. req_ready = 1. All other outputs 0.
- Reset mid-operation is asynchronous and immediate. The car position is lost and current_floor returns to 0.
- The comparator is combinational. Its results are sampled in the same cycle that target_floor and current_floor are presented.

States and transitions (Moore outputs, all registered):
- IDLE:
  - On req_valid with req_floor < NUM_FLOORS: latch target_floor, go to CHECK.
  - On req_valid with req_floor >= NUM_FLOORS: pulse req_err next cycle, stay IDLE, target_floor unchanged.
- CHECK (1 cycle), sampling the comparator:
  - cmp_equals only: go to DOOR_OPEN.
  - cmp_a_bigger only: go to MOVE_UP.
  - cmp_a_smaller only: go to MOVE_DOWN.
  - Any other combination (none, or more than one asserted): pulse cmp_fault, go to IDLE, no motion.
- MOVE_UP / MOVE_DOWN:
  - Timer counts 0..TRAVEL_CYCLES-1.
  - On the last count, current_floor increments (up) or decrements (down), timer clears, go to CHECK.
  - Saturation guard: never increment past NUM_FLOORS-1 and never decrement below 0. If the guard fires, pulse cmp_fault and go to IDLE.
- DOOR_OPEN:
  - Timer counts 0..DOOR_CYCLES-1.
  - On the last count, timer clears and the state goes to IDLE.
- No request queueing. req_valid outside IDLE is ignored and is not held pending.

Timing:
- Cost per floor traversed: TRAVEL_CYCLES + 1 cycles (the extra cycle is CHECK).
- Latency from acceptance to door_open: 2 + |target - current| * (TRAVEL_CYCLES + 1) cycles.
- motor_up and motor_down are never high together, and both are low during CHECK.

Decomposition:
- Shared package elevator_pkg:
  - state enum: IDLE, CHECK, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
  - FLOOR_W = 4.
  - floor_t typedef.
- Sub-module cycle_timer: a clear/enable up-counter with a terminal-count output, width derived from max(TRAVEL_CYCLES, DOOR_CYCLES). One instance is shared by the move and door states.
- The bench instantiates the real 4-bit comparator between target_floor/current_floor and the cmp_* inputs, except in the fault-injection test.

Test Plan:
1. Reset, then idle with no request -> current_floor = 0, req_ready = 1, busy = 0, all motor and door outputs 0.
2. Defaults; request floor 3 accepted at cycle 0 ->
   - CHECK at cycle 1; motor_up during cycles 2-5, 7-10 and 12-15.
   - current_floor becomes 1 at cycle 6, 2 at 11 and 3 at 16.
   - door_open during cycles 17-24; IDLE with req_ready = 1 at cycle 25.
3. From floor 3, request floor 1 -> motor_down only, two floor steps of 5 cycles each, then door_open for 8 cycles; current_floor ends at 1.
4. Request the current floor -> CHECK at cycle 1 sees cmp_equals, door_open during cycles 2-9, no motor activity.
5. NUM_FLOORS = 10, request 12 -> req_err pulses for exactly 1 cycle, state stays IDLE, target_floor unchanged.
   Separately, force cmp_* = 000 during CHECK -> cmp_fault pulses for 1 cycle, return to IDLE.
6. Assert rst_n low during MOVE_UP -> motor_up drops in the same cycle, current_floor = 0, and the next request executes normally.
